// File: rtl/fabric_alu_pkg.sv
// rtl/fabric_alu_pkg.sv - opcode map and helpers shared by the fabric ALU PE
package fabric_alu_pkg;

    localparam int ALU_NO_CONFIG_BITS = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_ACC  = 3'b110,
        OP_LOAD = 3'b111
    } alu_op_e;

    // True for the opcodes that write the accumulator
    function automatic logic alu_is_acc(input alu_op_e op);
        return (op == OP_ACC) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/fabric_alu_pe_if.sv
// rtl/fabric_alu_pe_if.sv - operand/result handshake bundle of the PE (flags under FABRIC_ALU_PE_FLAGS_EN)
interface fabric_alu_pe_if
    import fabric_alu_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int NoConfigBits = ALU_NO_CONFIG_BITS
);
    logic                    en;
    logic [WIDTH-1:0]        data_in1;
    logic [WIDTH-1:0]        data_in2;
    logic [WIDTH-1:0]        data_in3;
    logic                    in_valid;
    logic                    in_ready;
    logic [NoConfigBits-1:0] ConfigBits;
    logic [WIDTH-1:0]        data_out;
    logic                    out_valid;
    logic                    out_ready;
`ifdef FABRIC_ALU_PE_FLAGS_EN
    logic                    carry_out;
    logic                    zero_out;

    modport master (
        output en, data_in1, data_in2, data_in3, in_valid, ConfigBits, out_ready,
        input  in_ready, data_out, out_valid, carry_out, zero_out
    );
    modport slave (
        input  en, data_in1, data_in2, data_in3, in_valid, ConfigBits, out_ready,
        output in_ready, data_out, out_valid, carry_out, zero_out
    );
`else
    modport master (
        output en, data_in1, data_in2, data_in3, in_valid, ConfigBits, out_ready,
        input  in_ready, data_out, out_valid
    );
    modport slave (
        input  en, data_in1, data_in2, data_in3, in_valid, ConfigBits, out_ready,
        output in_ready, data_out, out_valid
    );
`endif
endinterface

// File: rtl/fabric_alu_core.sv
// rtl/fabric_alu_core.sv - combinational opcode datapath (carry output under FABRIC_ALU_PE_FLAGS_EN)
module fabric_alu_core
    import fabric_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
`ifdef FABRIC_ALU_PE_FLAGS_EN
    output logic             carry,
`endif
    output logic [WIDTH-1:0] next_acc
);
    localparam int SHW = $clog2(WIDTH);

`ifdef FABRIC_ALU_PE_FLAGS_EN
    // One extra bit keeps the carry; subtraction as a + ~b + 1 gives the inverted borrow
    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_sub;
    logic [WIDTH:0] sum_acc;
    assign sum_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign sum_acc = {1'b0, acc} + {1'b0, a};
`else
    logic [WIDTH-1:0] sum_add;
    logic [WIDTH-1:0] sum_sub;
    logic [WIDTH-1:0] sum_acc;
    assign sum_add = a + b + {{(WIDTH-1){1'b0}}, cin};
    assign sum_sub = a - b;
    assign sum_acc = acc + a;
`endif

    // Opcode decode into the registered result value
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = sum_add[WIDTH-1:0];
            OP_SUB:  result = sum_sub[WIDTH-1:0];
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << b[SHW-1:0];
            OP_ACC:  result = sum_acc[WIDTH-1:0];
            OP_LOAD: result = a;
            default: result = '0;
        endcase
    end

`ifdef FABRIC_ALU_PE_FLAGS_EN
    // Carry is meaningful only for the adding opcodes
    always_comb begin
        carry = 1'b0;
        case (op)
            OP_ADD:  carry = sum_add[WIDTH];
            OP_SUB:  carry = sum_sub[WIDTH];
            OP_ACC:  carry = sum_acc[WIDTH];
            default: carry = 1'b0;
        endcase
    end
`endif

    // For ACC and LOAD the result already is the new accumulator value
    assign next_acc = alu_is_acc(op) ? result : acc;

endmodule

// File: rtl/fabric_alu_pe.sv
// rtl/fabric_alu_pe.sv - two-stage valid/ready fabric ALU PE with accumulator; optional flags via FABRIC_ALU_PE_FLAGS_EN
module fabric_alu_pe
    import fabric_alu_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int NoConfigBits = ALU_NO_CONFIG_BITS
) (
    input  logic          clk,
    input  logic          rst,
    fabric_alu_pe_if.slave pe
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    alu_op_e          s1_op;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;

    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_next_acc;

    logic s2_free;
    logic s1_advance;
    logic accept;

    assign s2_free    = !out_valid || pe.out_ready;
    assign s1_advance = pe.en && s1_valid && s2_free;
    assign pe.in_ready = !rst && pe.en && (!s1_valid || s1_advance);
    assign accept     = pe.in_valid && pe.in_ready;

    assign pe.data_out  = out_data;
    assign pe.out_valid = out_valid;

`ifdef FABRIC_ALU_PE_FLAGS_EN
    logic alu_carry;
    logic carry_q;
    logic zero_q;
    assign pe.carry_out = carry_q;
    assign pe.zero_out  = zero_q;
`endif

    fabric_alu_core #(.WIDTH(WIDTH)) u_core (
        .op       (s1_op),
        .a        (s1_a),
        .b        (s1_b),
        .cin      (s1_cin),
        .acc      (acc),
        .result   (alu_result),
`ifdef FABRIC_ALU_PE_FLAGS_EN
        .carry    (alu_carry),
`endif
        .next_acc (alu_next_acc)
    );

    // Stage 1: capture operands and opcode at acceptance; opcode is frozen for the op's lifetime
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_op    <= OP_ADD;
        end else if (pe.en) begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= pe.data_in1;
                s1_b     <= pe.data_in2;
                s1_cin   <= pe.data_in3[0];
                s1_op    <= alu_op_e'(pe.ConfigBits);
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: load the result and commit the accumulator together; consume drops out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
        end else if (pe.en) begin
            if (s1_advance) begin
                out_valid <= 1'b1;
                out_data  <= alu_result;
                acc       <= alu_next_acc;
            end else if (out_valid && pe.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FABRIC_ALU_PE_FLAGS_EN
    // Flags travel with data_out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (s1_advance) begin
            carry_q <= alu_carry;
            zero_q  <= (alu_result == '0);
        end
    end
`endif

endmodule

// File: tb/tb_fabric_alu_pe.sv
// tb/tb_fabric_alu_pe.sv - self-checking bench for fabric_alu_pe with queue-based reference model
module tb_fabric_alu_pe;
    import fabric_alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fabric_alu_pe_if #(.WIDTH(W)) bus ();

    fabric_alu_pe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .pe  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ops complete in acceptance order, so the accumulator and
    // results are computed at acceptance; the queue holds accepted, unconsumed ops.
    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        logic         moved;
    } ent_t;

    ent_t         mq[$];
    logic [W-1:0] m_acc;
    logic [W-1:0] m_last;
    logic         m_cy;
    logic         m_z;
    bit           m_take;
    bit           m_pop;
    ent_t         m_new;

    task automatic model_exec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, output logic [W-1:0] res, output logic cy);
        logic [63:0] r;
        r   = '0;
        cy  = 1'b0;
        res = '0;
        case (op)
            3'd0: begin r = 64'(a) + 64'(b) + 64'(cin); res = r[W-1:0]; cy = r[W]; end
            3'd1: begin res = a - b; cy = (a >= b); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = a << (b % W);
            3'd6: begin r = 64'(m_acc) + 64'(a); m_acc = r[W-1:0]; res = m_acc; cy = r[W]; end
            default: begin m_acc = a; res = a; end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_acc  = '0;
            m_last = '0;
            m_cy   = 1'b0;
            m_z    = 1'b0;
        end else if (bus.en) begin
            m_take = bus.in_valid && (mq.size() < 2 || bus.out_ready);
            m_pop  = mq.size() > 0 && mq[0].moved && bus.out_ready;
            if (m_pop) void'(mq.pop_front());
            if (mq.size() > 0 && !mq[0].moved) begin
                mq[0].moved = 1'b1;
                m_last = mq[0].res;
                m_cy   = mq[0].cy;
                m_z    = (mq[0].res == '0);
            end
            if (m_take) begin
                model_exec(bus.ConfigBits, bus.data_in1, bus.data_in2, bus.data_in3[0], m_new.res, m_new.cy);
                m_new.moved = 1'b0;
                mq.push_back(m_new);
            end
        end
    end

    int          cyc = 0;
    logic [W-1:0] seen_data[$];
    int          seen_cyc[$];

    always @(posedge clk) cyc++;

    // Compare DUT outputs to the model every cycle; also log consumed results
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", bus.in_ready, bus.en && (mq.size() < 2 || bus.out_ready));
            check("out_valid", bus.out_valid, mq.size() > 0 && mq[0].moved);
            check("data_out", bus.data_out, m_last);
`ifdef FABRIC_ALU_PE_FLAGS_EN
            check("carry_out", bus.carry_out, m_cy);
            check("zero_out", bus.zero_out, m_z);
`endif
            if (bus.en && bus.out_valid && bus.out_ready) begin
                seen_data.push_back(bus.data_out);
                seen_cyc.push_back(cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bit got;
        got = 1'b0;
        bus.ConfigBits = op;
        bus.data_in1   = a;
        bus.data_in2   = b;
        bus.data_in3   = {{(W-1){1'b0}}, cin};
        bus.in_valid   = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("send_accepted", got, 1'b1);
    endtask

    task automatic check_seen(input string name, input int idx, input logic [W-1:0] exp);
        if (idx < seen_data.size()) check(name, seen_data[idx], exp);
        else check({name, "_missing"}, 64'(seen_data.size()), 64'(idx + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int acc_cnt;
    bit after2;
    bit r;
    int k;

    initial begin
        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.data_in1   = '0;
        bus.data_in2   = '0;
        bus.data_in3   = '0;
        bus.ConfigBits = '0;
        #12;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_data_out", bus.data_out, 32'h0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // ADD with wrap and carry; two-cycle latency
        send(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        @(negedge clk);
        check("add_lat_early", bus.out_valid, 1'b0);
        @(negedge clk);
        check("add_lat_valid", bus.out_valid, 1'b1);
        check("add_value", bus.data_out, 32'h0000_0001);
`ifdef FABRIC_ALU_PE_FLAGS_EN
        check("add_carry", bus.carry_out, 1'b1);
        check("add_zero", bus.zero_out, 1'b0);
`endif
        idle(2);

        seen_data.delete(); seen_cyc.delete();
        send(3'd1, 32'd3, 32'd5, 1'b0);
        send(3'd5, 32'd1, 32'h23, 1'b0);
        idle(4);
        check_seen("sub_wrap", 0, 32'hFFFF_FFFE);
        check_seen("shl_amt", 1, 32'h0000_0008);

        // LOAD 10, ACC 5, ACC 7 back-to-back
        seen_data.delete(); seen_cyc.delete();
        bus.in_valid = 1'b1; bus.ConfigBits = 3'd7; bus.data_in1 = 32'd10;
        idle(1);
        bus.ConfigBits = 3'd6; bus.data_in1 = 32'd5;
        idle(1);
        bus.data_in1 = 32'd7;
        idle(1);
        bus.in_valid = 1'b0;
        idle(4);
        check_seen("acc_load", 0, 32'd10);
        check_seen("acc_1", 1, 32'd15);
        check_seen("acc_2", 2, 32'd22);
        check("acc_seen_count", 64'(seen_data.size()), 64'd3);
        if (seen_cyc.size() == 3) begin
            check("acc_no_bubble_1", 64'(seen_cyc[1] - seen_cyc[0]), 64'd1);
            check("acc_no_bubble_2", 64'(seen_cyc[2] - seen_cyc[1]), 64'd1);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        idle(1);
        seen_data.delete(); seen_cyc.delete();
        send(3'd6, 32'd4, 32'd0, 1'b0);
        idle(4);
        check_seen("acc_after_rst", 0, 32'd4);

        // Backpressure: only two ops buffered
        seen_data.delete(); seen_cyc.delete();
        bus.out_ready = 1'b0;
        acc_cnt = 0; after2 = 1'b1; k = 0;
        bus.ConfigBits = 3'd0; bus.data_in2 = '0; bus.data_in3 = '0;
        bus.data_in1 = 32'd100; bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            r = bus.in_ready;
            if (acc_cnt == 2 && i > 0 && after2) begin
                check("bp_ready_drop", r, 1'b0);
                after2 = 1'b0;
            end
            if (r) acc_cnt++;
            @(posedge clk);
            #1;
            if (r) begin k++; bus.data_in1 = 32'(100 + k); end
        end
        check("bp_accept_count", 64'(acc_cnt), 64'd2);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        idle(5);
        check("bp_seen_count", 64'(seen_data.size()), 64'd2);
        check_seen("bp_first", 0, 32'd100);
        check_seen("bp_second", 1, 32'd101);

        // ConfigBits change after acceptance is ignored
        seen_data.delete(); seen_cyc.delete();
        send(3'd0, 32'd2, 32'd3, 1'b0);
        bus.ConfigBits = 3'd4;
        idle(4);
        check_seen("cfg_isolation", 0, 32'd5);

        // en=0 freezes output and ignores out_ready
        seen_data.delete(); seen_cyc.delete();
        bus.out_ready = 1'b0;
        send(3'd2, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
        idle(3);
        bus.en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("en0_valid_hold", bus.out_valid, 1'b1);
            check("en0_data_hold", bus.data_out, 32'h0000_F000);
        end
        @(posedge clk); #1;
        check("en0_not_consumed", 64'(seen_data.size()), 64'd0);
        bus.en = 1'b1;
        idle(2);
        check("en1_consumed", 64'(seen_data.size()), 64'd1);
        check_seen("en1_value", 0, 32'h0000_F000);

        // Asynchronous reset mid-pipeline
        bus.out_ready = 1'b0;
        send(3'd0, 32'd7, 32'd0, 1'b0);
        send(3'd0, 32'd8, 32'd0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_data_out", bus.data_out, 32'h0);
        check("arst_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        seen_data.delete(); seen_cyc.delete();
        idle(4);
        check("arst_discarded", 64'(seen_data.size()), 64'd0);

        // Randomized traffic against the model
        repeat (3000) begin
            @(posedge clk);
            #1;
            bus.en         = ($urandom_range(0, 7) != 0);
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            bus.in_valid   = $urandom_range(0, 1);
            bus.ConfigBits = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: bus.data_in1 = '0;
                1: bus.data_in1 = 32'hFFFF_FFFF;
                default: bus.data_in1 = $urandom;
            endcase
            bus.data_in2 = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
            bus.data_in3 = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        bus.en = 1'b1;
        bus.out_ready = 1'b1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fabric_alu_pe.md
Name: fabric_alu_pe

Overview:
- Fabric ALU processing element; this is the primitive that synthesis techmaps retarget generic arithmetic cells onto.
- Decodes the per-tile ConfigBits word into an operation and executes it on data_in1/data_in2 (data_in3 is the carry-in).
- Two-stage valid/ready pipeline with an internal accumulator.
- Sits in the CGRA/FPGA tile between routing muxes and the output switch box.

Parameters:
- WIDTH, 32, datapath width of data_in1..3 and data_out; minimum 8.
- NoConfigBits, 3, width of ConfigBits; fixed at 3 for this opcode map.

Ports:
- clk  input  1  fabric clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  tile enable; low freezes the whole PE.
- data_in1  input  WIDTH  operand A.
- data_in2  input  WIDTH  operand B.
- data_in3  input  WIDTH  carry-in; only bit 0 is used.
- in_valid  input  1  operands and ConfigBits are valid this cycle.
- in_ready  output  1  PE accepts operands this cycle.
- ConfigBits  input  NoConfigBits  opcode.
- data_out  output  WIDTH  registered result.
- out_valid  output  1  data_out holds an unconsumed result.
- out_ready  input  1  downstream consumes data_out.

Behaviour:
- Reset (async, rst=1): s1_valid=0, out_valid=0, data_out=0, accumulator=0, all stage registers 0. in_ready is 0 while rst is high.
- Opcodes:
  - 000 ADD: A+B+cin.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: A << B[$clog2(WIDTH)-1:0].
  - 110 ACC: acc <= acc + A; result = new acc.
  - 111 LOAD: acc <= A; result = A.
- All arithmetic is modulo 2^WIDTH; the carry-out is discarded unless FLAGS is enabled.
- Stage 1: on in_valid && in_ready, capture A, B, cin and the opcode. ConfigBits is sampled only at acceptance, so a ConfigBits change never affects an op already in flight.
- Stage 2: computes the result from the stage-1 registers and loads data_out when stage 1 advances.
- The accumulator updates only at that same stage-2 load.
- Advance rules:
  - s2_free = !out_valid || out_ready.
  - s1 advances when en && s1_valid && s2_free.
  - in_ready = en && (!s1_valid || s1_advance).
- Latency: 2 cycles from acceptance to out_valid with no stall. Throughput: 1 op/cycle.
- Full case: with out_valid=1 and out_ready=0 held, at most 2 ops are buffered (s1 + out) and in_ready drops to 0 on the following cycle.
- Simultaneous events:
  - s1 advance and new acceptance in the same cycle are both legal.
  - Consume and reload in the same cycle keep out_valid=1.
- en=0: no state changes, in_ready=0, outputs hold. out_valid stays asserted, but out_ready is ignored (the result is not consumed) until en returns.
- Reset mid-operation discards all in-flight ops and the accumulator.
- Back-to-back ACC ops see the updated accumulator with no bubble, because the update happens in stage 2 only.

Optional Feature:
- Macro: FABRIC_ALU_PE_FLAGS_EN.
- Defined:
  - Adds outputs carry_out (1) and zero_out (1), registered alongside data_out with the same reset value 0.
  - carry_out = bit WIDTH of ADD/ACC; for SUB it is the inverted borrow; 0 for the other ops.
  - zero_out = (result == 0).
- Undefined: ports absent, no flag logic.

Decomposition:
- Package fabric_alu_pkg holds:
  - opcode typedef enum alu_op_e with OP_ADD..OP_LOAD, 3 bits.
  - localparam ALU_NO_CONFIG_BITS=3.
  - a function alu_is_acc(op).
- One sub-module fabric_alu_core: purely combinational; inputs op, A, B, cin, acc; outputs result, next_acc, carry. The wrapper owns all registers and the handshake.

Test Plan:
- ADD: A=0xFFFFFFFF, B=1, cin=1, out_ready=1 -> data_out=0x00000001 two cycles after acceptance; with FLAGS, carry_out=1 and zero_out=0.
- SUB and wrap: A=3, B=5 -> data_out=0xFFFFFFFE; SHL with A=1, B=0x23 -> 0x00000008 (shift amount 3).
- Accumulator: LOAD 10, then ACC 5, ACC 7 on consecutive cycles -> outputs 10, 15, 22 on consecutive cycles; rst pulse -> next ACC 4 gives 4.
- Backpressure: hold out_ready=0 and stream 4 ops -> exactly 2 accepted, in_ready=0 from the cycle after the second acceptance. Release out_ready -> results emerge in order with no loss or duplication.
- Config isolation: accept ADD, then change ConfigBits to XOR the next cycle with in_valid=0 -> the in-flight result is still the sum.
- en=0 while out_valid=1 and out_ready=1 -> data_out and out_valid hold and nothing is consumed. rst asserted mid-pipeline -> out_valid=0 and data_out=0 immediately, asynchronously.
